// File: rtl/seg_pkg.sv
// Shared widths, anode encodings and digit-bundle type for the 4-digit
// multiplexed 7-segment scan path.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Indexed by select: entry 0 lights the ones digit.
  localparam logic [NUM_DIGITS-1:0][NUM_DIGITS-1:0] ANODE_SEL =
    {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Element 0 = ones ... element 3 = thousand.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;
endpackage

// File: rtl/seg_digit_sel.sv
// Combinational 4:1 nibble selector with leading-zero blanking decode.
module seg_digit_sel
  import seg_pkg::*;
(
  input  digits_t               disp,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  blank_en,
  output logic [DIGIT_W-1:0]    digit,
  output logic [NUM_DIGITS-1:0] anode
);

  logic [NUM_DIGITS-1:0] blanked;

  // A digit is a leading zero when it and every more-significant digit are 0;
  // the ones position is always shown.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_blank
    if (g == 0) begin : g_ones
      assign blanked[g] = 1'b0;
    end else if (g == NUM_DIGITS-1) begin : g_top
      assign blanked[g] = (disp[g] == '0);
    end else begin : g_mid
      assign blanked[g] = (disp[g] == '0) & blanked[g+1];
    end
  end

  always_comb begin
    digit = disp[sel];
    anode = ANODE_SEL[sel];
    if (blank_en && blanked[sel]) anode = ANODE_OFF;
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Digit scan controller: prescaled 2-bit select, staged digit load committed
// on frame boundaries, and leading-zero blanking toward the segment decoder.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int   CLK_DIV       = 100000,
  parameter logic BLANK_DEFAULT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundred,
  input  logic [3:0] thousand,
  input  logic       blank_lz,
  output logic [1:0] control,
  output logic [3:0] digit,
  output logic [3:0] anode,
  output logic       pending,
  output logic       frame_done
);

  localparam int             CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             commit;
  logic             blank_en;
  digits_t          disp;
  digits_t          stg;

  assign tick   = (cnt == CNT_MAX);
  // Commit only as the thousand slot ends, so a whole frame shows one value.
  assign commit = tick && (control == 2'd3) && pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      control    <= '0;
      disp       <= '0;
      stg        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      blank_en   <= BLANK_DEFAULT;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      blank_en   <= blank_lz;
      frame_done <= commit;
      if (tick)   control <= control + 1'b1;
      if (commit) disp    <= stg;
      // A load coinciding with a commit stages the new value for the next frame.
      if (load) begin
        stg     <= {thousand, hundred, tens, ones};
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  seg_digit_sel u_sel (
    .disp     (disp),
    .sel      (control),
    .blank_en (blank_en),
    .digit    (digit),
    .anode    (anode)
  );

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_seg_scan_controller;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset, load, blank_lz;
  logic [3:0] ones, tens, hundred, thousand;
  logic [1:0] control;
  logic [3:0] digit, anode;
  logic       pending, frame_done;

  seg_scan_controller #(.CLK_DIV(DIV), .BLANK_DEFAULT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .ones       (ones),
    .tens       (tens),
    .hundred    (hundred),
    .thousand   (thousand),
    .blank_lz   (blank_lz),
    .control    (control),
    .digit      (digit),
    .anode      (anode),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ctl;
    int dig;
    int an;
    int pend;
    int fd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int   m_t = 0;
  int   m_disp[4];
  int   m_stg[4];
  bit   m_pend, m_fd, m_blank;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame position is just the cycle count since reset modulo one frame.
  initial begin : model
    exp_t e;
    bit   bnd, lit;
    int   sel;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_t = 0; m_pend = 0; m_fd = 0; m_blank = 0;
        for (int i = 0; i < 4; i++) begin m_disp[i] = 0; m_stg[i] = 0; end
      end else begin
        bnd  = (m_t == FRAME - 1);
        m_fd = bnd && m_pend;
        if (m_fd) begin m_disp = m_stg; m_pend = 0; end
        if (load) begin
          m_stg[0] = ones; m_stg[1] = tens; m_stg[2] = hundred; m_stg[3] = thousand;
          m_pend = 1;
        end
        m_blank = blank_lz;
        m_t = (m_t + 1) % FRAME;
      end
      sel = m_t / DIV;
      lit = (sel == 0);
      for (int j = sel; j < 4; j++) if (m_disp[j] != 0) lit = 1;
      e.ctl  = sel;
      e.dig  = m_disp[sel];
      e.an   = (m_blank && !lit) ? 15 : (15 & ~(1 << sel));
      e.pend = m_pend;
      e.fd   = m_fd;
      q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("control", control, e.ctl);
        chk("digit", digit, e.dig);
        chk("anode", anode, e.an);
        chk("pending", pending, e.pend);
        chk("frame_done", frame_done, e.fd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_t(input int target);
    int k = 0;
    while (m_t != target && k < 100) begin step(); k++; end
    if (k >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL wait_t: frame position %0d never reached", target);
    end
  endtask

  task automatic do_load(input int o, input int t, input int h, input int th);
    ones = 4'(o); tens = 4'(t); hundred = 4'(h); thousand = 4'(th);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  function automatic int rdig();
    case ($urandom % 4)
      0:       return 0;
      1:       return int'($urandom % 16);
      default: return int'($urandom % 10);
    endcase
  endfunction

  initial begin : stim
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0;
    ones = '0; tens = '0; hundred = '0; thousand = '0;
    repeat (2) step();
    reset = 1'b0;
    repeat (20) step();

    // Mid-frame load, committed on the next 3->0 tick
    wait_t(6);  do_load(1, 2, 3, 4);  repeat (40) step();

    // Two loads in one frame: latest wins, single commit
    wait_t(2);  do_load(5, 5, 5, 5);  repeat (3) step();
    do_load(6, 7, 8, 9);              repeat (36) step();

    // Load landing exactly on the commit cycle
    wait_t(3);  do_load(1, 1, 1, 1);
    wait_t(FRAME - 1); do_load(9, 9, 9, 9);
    repeat (40) step();

    // Leading-zero blanking
    blank_lz = 1'b1;
    wait_t(0);  do_load(7, 0, 0, 0);  repeat (40) step();
    do_load(0, 0, 0, 0);              repeat (40) step();
    do_load(0, 3, 0, 0);              repeat (40) step();
    blank_lz = 1'b0;                  repeat (8) step();

    // Reset while control = 2 with a pending load
    do_load(3, 0, 5, 0);
    wait_t(2 * DIV + 1);
    reset = 1'b1; step(); reset = 1'b0;
    repeat (20) step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom % 8 == 0);
      if (load) begin
        ones = 4'(rdig()); tens = 4'(rdig()); hundred = 4'(rdig()); thousand = 4'(rdig());
      end
      if ($urandom % 16 == 0) blank_lz = ~blank_lz;
      reset = ($urandom % 300 == 0);
      step();
    end
    load = 1'b0; reset = 1'b0;
    repeat (2) step();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
